// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: configuration owner and frame buffer for the 16x-oversampled
// UART receive processor. Host config writes are staged and applied only once
// the line has been idle for QUIET_CYCLES samples. Completed frames are
// captured on the rising edge of frame_valid into a first-word-fall-through FIFO.
module uart_rx_ctrl #(
    parameter int DEPTH        = 8,
    parameter int QUIET_CYCLES = 208
) (
    input  logic                     clk_16bd,
    input  logic                     rst,
    input  logic                     Rx,
    input  logic                     cfg_wr,
    input  logic                     cfg_parity,
    input  logic                     cfg_parity_type,
    input  logic                     cfg_stop_bits,
    input  logic [3:0]               cfg_frame_length,
    output logic                     cfg_busy,
    output logic                     cfg_done,
    output logic                     cfg_err,
    output logic                     parity,
    output logic                     parity_type,
    output logic                     stop_bits,
    output logic [3:0]               frame_length,
    input  logic [8:0]               frame,
    input  logic                     frame_valid,
    input  logic                     rd_en,
    output logic [8:0]               dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int QW = $clog2(QUIET_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_QUIET = 2'd1,
        ST_APPLY      = 2'd2
    } state_t;

    // Data-bit counts the processor can actually frame.
    function automatic logic len_legal(input logic [3:0] len);
        return (len >= 4'd5) && (len <= 4'd9);
    endfunction

    state_t          state_q, state_d;
    logic [QW-1:0]   quiet_q, quiet_d;
    logic            stg_par_q, stg_par_d;
    logic            stg_ptype_q, stg_ptype_d;
    logic            stg_stop_q, stg_stop_d;
    logic [3:0]      stg_len_q, stg_len_d;
    logic            par_q, par_d;
    logic            ptype_q, ptype_d;
    logic            stop_q, stop_d;
    logic [3:0]      len_q, len_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            wr_ok, wr_bad;

    logic            fv_q, fv_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            push, do_push, do_pop;
    logic [8:0]      mem_q [DEPTH];

    // Config FSM: stage legal writes, wait for a quiet line, then apply atomically.
    always_comb begin
        state_d     = state_q;
        quiet_d     = quiet_q;
        stg_par_d   = stg_par_q;
        stg_ptype_d = stg_ptype_q;
        stg_stop_d  = stg_stop_q;
        stg_len_d   = stg_len_q;
        par_d       = par_q;
        ptype_d     = ptype_q;
        stop_d      = stop_q;
        len_d       = len_q;
        done_d      = 1'b0;
        wr_ok       = cfg_wr & len_legal(cfg_frame_length);
        wr_bad      = cfg_wr & ~len_legal(cfg_frame_length);
        err_d       = wr_bad;
        if (wr_ok) begin
            stg_par_d   = cfg_parity;
            stg_ptype_d = cfg_parity_type;
            stg_stop_d  = cfg_stop_bits;
            stg_len_d   = cfg_frame_length;
        end
        case (state_q)
            ST_IDLE: begin
                quiet_d = '0;
                if (wr_ok) state_d = ST_WAIT_QUIET;
            end
            ST_WAIT_QUIET: begin
                if (!Rx)
                    quiet_d = '0;
                else if (quiet_q != QW'(QUIET_CYCLES))
                    quiet_d = quiet_q + QW'(1);
                // Config registers load on entry to APPLY so the done pulse
                // and the new values appear together. A write arriving on this
                // same cycle is the latest one, so it is the one applied.
                if (quiet_d == QW'(QUIET_CYCLES)) begin
                    state_d = ST_APPLY;
                    par_d   = stg_par_d;
                    ptype_d = stg_ptype_d;
                    stop_d  = stg_stop_d;
                    len_d   = stg_len_d;
                    done_d  = 1'b1;
                end
            end
            ST_APPLY: begin
                quiet_d = '0;
                // A legal write landing on the apply cycle starts a fresh wait
                // rather than being lost.
                state_d = wr_ok ? ST_WAIT_QUIET : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                quiet_d = '0;
            end
        endcase
    end

    // Config state, staging and output registers.
    always_ff @(posedge clk_16bd or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            quiet_q     <= '0;
            stg_par_q   <= 1'b0;
            stg_ptype_q <= 1'b0;
            stg_stop_q  <= 1'b0;
            stg_len_q   <= 4'd8;
            par_q       <= 1'b0;
            ptype_q     <= 1'b0;
            stop_q      <= 1'b0;
            len_q       <= 4'd8;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            quiet_q     <= quiet_d;
            stg_par_q   <= stg_par_d;
            stg_ptype_q <= stg_ptype_d;
            stg_stop_q  <= stg_stop_d;
            stg_len_q   <= stg_len_d;
            par_q       <= par_d;
            ptype_q     <= ptype_d;
            stop_q      <= stop_d;
            len_q       <= len_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // FIFO control: edge-detect frame_valid, resolve push/pop/overflow.
    always_comb begin
        fv_d     = frame_valid;
        push     = frame_valid & ~fv_q;
        do_pop   = rd_en & (count_q != '0);
        // A pop on a full FIFO frees the slot the push needs.
        do_push  = push & ((count_q != CW'(DEPTH)) | do_pop);
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop)
            count_d = count_q + CW'(1);
        else if (do_pop && !do_push)
            count_d = count_q - CW'(1);
        ovf_d = ovf_q;
        if (push && !do_push)
            ovf_d = 1'b1;
        else if (ovf_clr)
            ovf_d = 1'b0;
    end

    // FIFO control registers.
    always_ff @(posedge clk_16bd or posedge rst) begin
        if (rst) begin
            fv_q     <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            fv_q     <= fv_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents are only meaningful behind the count, so no reset.
    always_ff @(posedge clk_16bd) begin
        if (do_push) mem_q[wr_ptr_q] <= frame;
    end

    assign cfg_busy     = (state_q == ST_WAIT_QUIET);
    assign cfg_done     = done_q;
    assign cfg_err      = err_q;
    assign parity       = par_q;
    assign parity_type  = ptype_q;
    assign stop_bits    = stop_q;
    assign frame_length = len_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign dout         = empty ? 9'd0 : mem_q[rd_ptr_q];

endmodule
